// File: rtl/spm_serial_driver.sv
// Sequencer for the spm serial-parallel multiplier: parallel operands in, serial y out, serial p in,
// 2*W-bit signed product out. Optional accumulator enabled by defining SPM_DRV_ACC_EN.
module spm_serial_driver #(
    parameter int unsigned W     = 32,
    parameter int unsigned P_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_clr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    output logic [W-1:0]   spm_x,
    output logic           spm_y,
    input  logic           spm_p,
    output logic           spm_rst,
    output logic           busy
);

    localparam int unsigned PW     = 2 * W;
    localparam int unsigned NCommit = 2 * W + P_LAT;
    localparam int unsigned CntW   = $clog2(NCommit + 1);

    localparam logic [CntW-1:0] CapFirst  = CntW'(P_LAT);
    localparam logic [CntW-1:0] CapLast   = CntW'(NCommit - 1);
    localparam logic [CntW-1:0] CntCommit = CntW'(NCommit);
    localparam logic [CntW-1:0] YLast     = CntW'(PW - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-2:0]    shreg_q, shreg_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [PW-1:0]   out_p_q, out_p_d;
    logic [W-1:0]    spm_x_q, spm_x_d;
    logic            spm_y_q, spm_y_d;
    logic            spm_rst_q, spm_rst_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   result;

`ifdef SPM_DRV_ACC_EN
    logic [PW-1:0] acc_q, acc_d;
    logic          clr_q, clr_d;

    // The last product bit is already in prod_q one cycle before commit.
    assign result = (clr_q ? '0 : acc_q) + prod_q;
`else
    logic unused_clr;

    assign unused_clr = in_clr;
    assign result     = prod_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        prod_d      = prod_q;
        out_p_d     = out_p_q;
        spm_x_d     = spm_x_q;
        spm_y_d     = spm_y_q;
        spm_rst_d   = spm_rst_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
`ifdef SPM_DRV_ACC_EN
        acc_d       = acc_q;
        clr_d       = clr_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d    = StRun;
                    cnt_d      = '0;
                    spm_x_d    = in_a;
                    shreg_d    = in_b[W-1:1];
                    spm_y_d    = in_b[0];
                    spm_rst_d  = 1'b0;
                    prod_d     = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef SPM_DRV_ACC_EN
                    clr_d      = in_clr;
`endif
                end
            end

            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                // Arithmetic shift keeps feeding the sign bit once the operand is exhausted.
                shreg_d = $unsigned($signed(shreg_q) >>> 1);
                spm_y_d = (cnt_q < YLast) ? shreg_q[0] : 1'b0;

                if (cnt_q >= CapFirst && cnt_q <= CapLast) begin
                    prod_d = {spm_p, prod_q[PW-1:1]};
                end

                if (cnt_q == CntCommit) begin
                    state_d     = StDone;
                    cnt_d       = cnt_q;
                    out_p_d     = result;
                    out_valid_d = 1'b1;
                    spm_rst_d   = 1'b1;
                    spm_y_d     = 1'b0;
`ifdef SPM_DRV_ACC_EN
                    acc_d       = result;
`endif
                end
            end

            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shreg_q     <= '0;
            prod_q      <= '0;
            out_p_q     <= '0;
            spm_x_q     <= '0;
            spm_y_q     <= 1'b0;
            spm_rst_q   <= 1'b1;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            prod_q      <= prod_d;
            out_p_q     <= out_p_d;
            spm_x_q     <= spm_x_d;
            spm_y_q     <= spm_y_d;
            spm_rst_q   <= spm_rst_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SPM_DRV_ACC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            clr_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            clr_q <= clr_d;
        end
    end
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign spm_x     = spm_x_q;
    assign spm_y     = spm_y_q;
    assign spm_rst   = spm_rst_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spm_serial_driver.sv
// Bench for spm_serial_driver: behavioural multiplier-array model on the serial side,
// products checked against plain signed arithmetic (plus accumulator model if SPM_DRV_ACC_EN).
module tb_spm_serial_driver;

    localparam int unsigned W     = 32;
    localparam int unsigned P_LAT = 1;
    localparam int unsigned PW    = 2 * W;
    localparam int unsigned LAT   = 2 * W + P_LAT + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_p;
    logic [W-1:0]  spm_x;
    logic          spm_y;
    logic          spm_p;
    logic          spm_rst;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    logic [PW-1:0] acc_m = '0;

    spm_serial_driver #(.W(W), .P_LAT(P_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_clr    (in_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_p     (spm_p),
        .spm_rst   (spm_rst),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Array model: bit k of x*y depends only on y bits 0..k, so it is final once bit k arrives.
    logic [PW-1:0] y_acc;
    logic [PW-1:0] pbits;
    int            k_m;

    function automatic logic model_bit(input logic [W-1:0] x, input logic [PW-1:0] y,
                                       input int k);
        logic [PW-1:0] xs;
        logic [PW-1:0] pr;
        xs = {{W{x[W-1]}}, x};
        pr = xs * y;
        return pr[k];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || spm_rst) begin
            y_acc <= '0;
            pbits <= '0;
            k_m   <= 0;
        end else begin
            if (k_m < PW) begin
                y_acc     <= y_acc | (PW'(spm_y) << k_m);
                pbits[k_m] <= model_bit(spm_x, y_acc | (PW'(spm_y) << k_m), k_m);
            end
            if (k_m < 1000) k_m <= k_m + 1;
        end
    end

    assign spm_p = (k_m >= P_LAT && (k_m - P_LAT) < PW) ? pbits[k_m-P_LAT] : 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic clr,
                          input int hold, input bit inject, input string tag);
        longint        sa;
        longint        sb;
        logic [PW-1:0] exp;
        int            n;
        int            waits;
        bit            x_bad;
        bit            ir_bad;
        bit            hold_bad;

        sa  = $signed(a);
        sb  = $signed(b);
        exp = PW'(sa * sb);
`ifdef SPM_DRV_ACC_EN
        exp = (clr ? '0 : acc_m) + exp;
`endif

        waits = 0;
        while (!in_ready && waits < 10) begin
            @(posedge clk);
            #1;
            waits++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'd1);

        out_ready = (hold == 0);
        in_a      = a;
        in_b      = b;
        in_clr    = clr;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        n      = 0;
        x_bad  = 1'b0;
        ir_bad = 1'b0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (spm_x !== a) x_bad = 1'b1;
            if (in_ready !== 1'b0 || busy !== 1'b1) ir_bad = 1'b1;
            if (inject) begin
                if (n == 5) begin
                    in_a     = ~a;
                    in_b     = ~b;
                    in_clr   = ~clr;
                    in_valid = 1'b1;
                end else if (n == 6) begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        check({tag, "_prod"}, out_p, exp);
        check({tag, "_spm_x_run"}, 64'(x_bad), 64'd0);
        check({tag, "_busy_run"}, 64'(ir_bad), 64'd0);
`ifdef SPM_DRV_ACC_EN
        acc_m = exp;
`endif

        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_p !== exp || in_ready !== 1'b0) hold_bad = 1'b1;
        end
        if (hold > 0) check({tag, "_hold"}, 64'(hold_bad), 64'd0);
        out_ready = 1'b1;

        @(posedge clk);
        #1;
        check({tag, "_post_handshake"}, {61'd0, out_valid, in_ready, spm_rst}, 64'b011);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_p", out_p, 64'd0);
        check("rst_spm_x", 64'(spm_x), 64'd0);
        check("rst_spm_y", 64'(spm_y), 64'd0);
        check("rst_spm_rst", 64'(spm_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(32'd3, 32'd5, 1'b1, 0, 1'b0, "a3b5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, "m1m1");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0, "minmin");
        run_op(-32'sd7, 32'd6, 1'b1, 20, 1'b0, "m7x6_hold");
        run_op(32'd12345, -32'sd678, 1'b1, 1, 1'b1, "inject");

        // Reset while cnt==10; the partial product must be dropped.
        in_a     = 32'd99;
        in_b     = 32'd77;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_state", {60'd0, out_valid, spm_rst, in_ready, busy}, 64'b0110);
        acc_m = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(32'd2, 32'd3, 1'b1, 0, 1'b0, "after_rst");

        run_op(32'd2, 32'd3, 1'b1, 0, 1'b0, "acc_a");
        run_op(32'd4, 32'd5, 1'b0, 0, 1'b0, "acc_b");
        run_op(32'd1, 32'd1, 1'b1, 0, 1'b0, "acc_c");

        for (int i = 0; i < 8; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
